// File: rtl/fib_datapath_pkg.sv
// -----------------------------------------------------------------------------
// fib_datapath_pkg
// Shared encodings for the iterative-sum controller and its datapath:
//   alu_op_e  : ALU opcode carried on cnt_alu
//   reg_idx_e : register-file write destination carried on slc_reg
//   sel_e     : operand-mux select carried on slc_mux_a / slc_mux_b
// -----------------------------------------------------------------------------
package fib_datapath_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      REG_R0   = 2'b00,
      REG_R1   = 2'b01,
      REG_R2   = 2'b10,
      REG_NONE = 2'b11
   } reg_idx_e;

   typedef enum logic [1:0] {
      SEL_R0   = 2'b00,
      SEL_R1   = 2'b01,
      SEL_R2   = 2'b10,
      SEL_ZERO = 2'b11
   } sel_e;

   localparam int unsigned ITER_W   = 8;
   localparam logic [ITER_W-1:0] ITER_MAX = '1;

endpackage

// File: rtl/fib_datapath_alu.sv
// -----------------------------------------------------------------------------
// dp_alu
// Combinational ALU for fib_datapath.
// Ports:
//   op : ALU opcode (add / sub / and / or)
//   a  : operand A, WIDTH bits
//   b  : operand B, WIDTH bits
//   y  : result, WIDTH bits (modulo 2^WIDTH)
//   c  : carry-out for add, borrow (a < b unsigned) for sub, 0 otherwise
// -----------------------------------------------------------------------------
module dp_alu
   import fib_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             c
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   // One extra bit on both paths: bit WIDTH is the carry for the sum and,
   // because the subtraction wraps negative, the borrow for the difference.
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      y = '0;
      c = 1'b0;
      case (op)
         ALU_ADD: begin
            y = w_sum[WIDTH-1:0];
            c = w_sum[WIDTH];
         end
         ALU_SUB: begin
            y = w_diff[WIDTH-1:0];
            c = w_diff[WIDTH];
         end
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         default: begin
            y = '0;
            c = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/fib_datapath.sv
// -----------------------------------------------------------------------------
// fib_datapath
// Datapath responder for the iterative-sum controller: three-entry register
// file, registered ALU stage, sticky overflow, saturating R2 write counter and
// the threshold comparator that ends the controller's loop.
// Parameters:
//   WIDTH : data word width
//   INIT0 : reset value of R0
//   INIT1 : reset value of R1
//   LIMIT : mayor asserts when R2 > LIMIT (unsigned)
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   cnt_alu   : ALU opcode
//   slc_mux_a : operand A select (R0 / R1 / R2 / zero)
//   slc_mux_b : operand B select (R0 / R1 / R2 / zero)
//   slc_reg   : write destination (R0 / R1 / R2 / none)
//   w         : write strobe; stores the registered ALU result
//   mayor     : (R2 > LIMIT) | ovf
//   result    : current R2
//   iter      : saturating count of writes into R2
//   ovf       : sticky carry/borrow seen on an effective write
// -----------------------------------------------------------------------------
module fib_datapath
   import fib_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned INIT0 = 0,
   parameter int unsigned INIT1 = 1,
   parameter int unsigned LIMIT = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cnt_alu,
   input  logic [1:0]        slc_mux_a,
   input  logic [1:0]        slc_mux_b,
   input  logic [1:0]        slc_reg,
   input  logic              w,
   output logic              mayor,
   output logic [WIDTH-1:0]  result,
   output logic [ITER_W-1:0] iter,
   output logic              ovf
);

   localparam logic [WIDTH-1:0] R0_RST = WIDTH'(INIT0);
   localparam logic [WIDTH-1:0] R1_RST = WIDTH'(INIT1);

   logic [WIDTH-1:0]  r_r0;
   logic [WIDTH-1:0]  r_r1;
   logic [WIDTH-1:0]  r_r2;
   logic [WIDTH-1:0]  r_acc;
   logic              r_acc_c;
   logic [ITER_W-1:0] r_iter;
   logic              r_ovf;

   logic [WIDTH-1:0]  w_op_a;
   logic [WIDTH-1:0]  w_op_b;
   logic [WIDTH-1:0]  w_alu_y;
   logic              w_alu_c;
   logic              w_wr_en;

   // ---------------- operand muxes ----------------
   always_comb begin
      w_op_a = '0;
      case (slc_mux_a)
         SEL_R0:  w_op_a = r_r0;
         SEL_R1:  w_op_a = r_r1;
         SEL_R2:  w_op_a = r_r2;
         default: w_op_a = '0;
      endcase
   end

   always_comb begin
      w_op_b = '0;
      case (slc_mux_b)
         SEL_R0:  w_op_b = r_r0;
         SEL_R1:  w_op_b = r_r1;
         SEL_R2:  w_op_b = r_r2;
         default: w_op_b = '0;
      endcase
   end

   dp_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op (alu_op_e'(cnt_alu)),
      .a  (w_op_a),
      .b  (w_op_b),
      .y  (w_alu_y),
      .c  (w_alu_c)
   );

   // ---------------- registered ALU stage ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc   <= '0;
         r_acc_c <= 1'b0;
      end else begin
         r_acc   <= w_alu_y;
         r_acc_c <= w_alu_c;
      end
   end

   // w gates the destination check so unknown selects cannot leak into state
   // while no write is requested.
   assign w_wr_en = w && (slc_reg != REG_NONE);

   // ---------------- register file, overflow, iteration count ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_r0   <= R0_RST;
         r_r1   <= R1_RST;
         r_r2   <= '0;
         r_iter <= '0;
         r_ovf  <= 1'b0;
      end else if (w_wr_en) begin
         case (slc_reg)
            REG_R0: r_r0 <= r_acc;
            REG_R1: r_r1 <= r_acc;
            REG_R2: begin
               r_r2 <= r_acc;
               if (r_iter != ITER_MAX) r_iter <= r_iter + 1'b1;
            end
            default: ;
         endcase
         if (r_acc_c) r_ovf <= 1'b1;
      end
   end

   // ---------------- outputs ----------------
   assign mayor  = (32'(r_r2) > LIMIT) | r_ovf;
   assign result = r_r2;
   assign iter   = r_iter;
   assign ovf    = r_ovf;

endmodule
